// File: rtl/conv_pkg.sv
// Shared types, constants and helpers for the convolution post-processing blocks.
package conv_pkg;

    localparam int DEF_ROI_SIZE      = 480;
    localparam int DEF_NUM_PER_CYCLE = 16;
    localparam int BEATS_PER_ROW     = DEF_ROI_SIZE / DEF_NUM_PER_CYCLE;
    localparam int POOL_PER_BEAT     = DEF_NUM_PER_CYCLE / 2;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        EVEN_ROW = 4'b0010,
        ODD_ROW  = 4'b0100,
        DRAIN    = 4'b1000
    } pool_state_t;

    // Clamp a non-negative value to the largest out_w-bit unsigned number.
    function automatic logic [31:0] sat_u(input logic [31:0] v, input int out_w);
        logic [31:0] max_v;
        max_v = (32'd1 << out_w) - 32'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer for the pooling stage: one write port, one asynchronous read port.
module pool_line_buffer #(
    parameter int DEPTH = 30,
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; every odd-row read hits an entry written by the preceding even row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_quant_maxpool.sv
// ReLU + requantize + 2x2 stride-2 max pooling of convolution_core sums.
// Define RELU_QUANT_ROUND_EN for round-half-up requantization instead of truncation.
module relu_quant_maxpool
    import conv_pkg::*;
#(
    parameter int ROI_SIZE      = DEF_ROI_SIZE,
    parameter int NUM_PER_CYCLE = DEF_NUM_PER_CYCLE,
    parameter int IN_W          = 17,
    parameter int OUT_W         = 8,
    parameter int SHIFT         = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clk_en,
    input  logic                                  pool_en,
    input  logic [NUM_PER_CYCLE-1:0][IN_W-1:0]    din,
    input  logic                                  din_vld,
    output logic [NUM_PER_CYCLE/2-1:0][OUT_W-1:0] dout,
    output logic                                  dout_vld,
    output logic                                  frame_done
);

    localparam int BEATS  = ROI_SIZE / NUM_PER_CYCLE;
    localparam int POOL_N = NUM_PER_CYCLE / 2;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW     = (ROI_SIZE > 1) ? $clog2(ROI_SIZE) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    pool_state_t   state, state_next;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] row_cnt;
    logic          drain_cnt;
    logic          in_row, accept, row_end, frame_end;

    assign in_row    = (state == EVEN_ROW) || (state == ODD_ROW);
    assign accept    = clk_en && pool_en && din_vld && in_row;
    assign row_end   = accept && (beat_cnt == BW'(BEATS - 1));
    assign frame_end = row_end && (state == ODD_ROW) && (row_cnt == RW'(ROI_SIZE - 1));

    // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (!pool_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     state_next = EVEN_ROW;
                EVEN_ROW: if (row_end) state_next = ODD_ROW;
                ODD_ROW:  if (row_end) state_next = frame_end ? DRAIN : EVEN_ROW;
                DRAIN:    if (drain_cnt) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            row_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else if (clk_en) begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (!pool_en || state == IDLE) begin
                beat_cnt <= '0;
                row_cnt  <= '0;
            end else if (row_end) begin
                beat_cnt <= '0;
                row_cnt  <= row_cnt + 1'b1;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Stage 1: ReLU, shift, saturate
    logic [NUM_PER_CYCLE-1:0][OUT_W-1:0] q_next, s1_q;
    logic                                s1_vld, s1_odd, s1_last;
    logic [BW-1:0]                       s1_beat;

    always_comb begin
        q_next = '0;
        for (int i = 0; i < NUM_PER_CYCLE; i++) begin
            logic [31:0] r;
            r = din[i][IN_W-1] ? 32'd0 : 32'(din[i][IN_W-2:0]);
`ifdef RELU_QUANT_ROUND_EN
            if (SHIFT > 0) r = r + (32'd1 << RND_SH);
`endif
            q_next[i] = OUT_W'(sat_u(r >> SHIFT, OUT_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s1_vld  <= 1'b0;
            s1_odd  <= 1'b0;
            s1_last <= 1'b0;
            s1_beat <= '0;
        end else if (clk_en) begin
            s1_vld <= accept;
            if (accept) begin
                s1_q    <= q_next;
                s1_odd  <= (state == ODD_ROW);
                s1_last <= frame_end;
                s1_beat <= beat_cnt;
            end
        end
    end

    // Stage 2: horizontal max, then vertical max against the buffered even row
    logic [POOL_N-1:0][OUT_W-1:0] h_row, lb_row, pooled;

    always_comb begin
        h_row  = '0;
        pooled = '0;
        for (int j = 0; j < POOL_N; j++) begin
            h_row[j]  = (s1_q[2*j] > s1_q[2*j+1]) ? s1_q[2*j] : s1_q[2*j+1];
            pooled[j] = (h_row[j] > lb_row[j]) ? h_row[j] : lb_row[j];
        end
    end

    pool_line_buffer #(
        .DEPTH (BEATS),
        .WIDTH (POOL_N * OUT_W),
        .AW    (BW)
    ) u_line_buf (
        .clk   (clk),
        .we    (clk_en && pool_en && s1_vld && !s1_odd),
        .waddr (s1_beat),
        .wdata (h_row),
        .raddr (s1_beat),
        .rdata (lb_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
        end else if (clk_en) begin
            if (!pool_en) begin
                dout_vld   <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                dout_vld   <= s1_vld && s1_odd;
                frame_done <= s1_vld && s1_odd && s1_last;
                if (s1_vld && s1_odd) dout <= pooled;
            end
        end
    end

endmodule
